// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: game state encoding, sprite geometry and fruit placement.
// color_mapper imports the same fruit coordinates so the rule engine and display agree.
package pacman_pkg;

  typedef enum logic [1:0] {
    PLAY,
    DYING,
    GAME_OVER
  } game_state_e;

  localparam int unsigned SPRITE_SIZE = 8;

  localparam logic [9:0] FRUIT_X0_DEF = 10'd104;
  localparam logic [9:0] FRUIT_Y0_DEF = 10'd96;
  localparam logic [9:0] FRUIT_X1_DEF = 10'd300;
  localparam logic [9:0] FRUIT_Y1_DEF = 10'd300;
  localparam logic [9:0] FRUIT_X2_DEF = 10'd400;
  localparam logic [9:0] FRUIT_Y2_DEF = 10'd50;

endpackage

// File: rtl/sprite_overlap.sv
// Combinational overlap test between two SPRITE_SIZE x SPRITE_SIZE sprites given their
// top-left corners; hit when both axis distances are strictly inside the sprite size.
module sprite_overlap
  import pacman_pkg::*;
(
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  output logic       hit
);

  localparam logic signed [10:0] Lim = 11'(SPRITE_SIZE);

  logic signed [10:0] dx;
  logic signed [10:0] dy;

  assign dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign hit = (dx > -Lim) && (dx < Lim) && (dy > -Lim) && (dy < Lim);

endmodule

// File: rtl/game_state_ctrl.sv
// Per-frame game-rule engine: collisions, lives, fruit/score bookkeeping and mouth
// animation, evaluated once per rising edge of frame_clk.
module game_state_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned MOUTH_FRAMES = 8,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter logic [9:0]  FRUIT_X0     = FRUIT_X0_DEF,
  parameter logic [9:0]  FRUIT_Y0     = FRUIT_Y0_DEF,
  parameter logic [9:0]  FRUIT_X1     = FRUIT_X1_DEF,
  parameter logic [9:0]  FRUIT_Y1     = FRUIT_Y1_DEF,
  parameter logic [9:0]  FRUIT_X2     = FRUIT_X2_DEF,
  parameter logic [9:0]  FRUIT_Y2     = FRUIT_Y2_DEF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_clk,
  input  logic            restart,
  input  logic [9:0]      pacmanX,
  input  logic [9:0]      pacmanY,
  input  logic [9:0]      ghost_redX,
  input  logic [9:0]      ghost_redY,
  input  logic [9:0]      ghost_greenX,
  input  logic [9:0]      ghost_greenY,
  input  logic [9:0]      ghost_aquaX,
  input  logic [9:0]      ghost_aquaY,
  output logic [5:0][9:0] fruit_location,
  output logic            first_on,
  output logic            second_on,
  output logic            third_on,
  output logic            death,
  output logic            closePacman,
  output logic            pacman_respawn,
  output logic [2:0]      lives,
  output logic [7:0]      score
);

  localparam logic [2:0] LivesInit = 3'(LIVES);
  localparam logic [7:0] MouthLast = 8'(MOUTH_FRAMES - 1);
  localparam logic [7:0] DeathLast = 8'(DEATH_FRAMES - 1);

  game_state_e state_q, state_d;
  logic        frame_clk_q;
  logic [2:0]  on_q, on_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  mouth_cnt_q, mouth_cnt_d;
  logic [7:0]  death_cnt_q, death_cnt_d;
  logic        close_q, close_d;
  logic        respawn_q, respawn_d;

  logic        tick;
  logic [2:0]  ghost_hit;
  logic [2:0]  fruit_hit;
  logic [2:0]  eaten;
  logic [2:0]  on_after;
  logic [9:0]  score_sum;

  logic [2:0][9:0] gx, gy, fx, fy;

  assign gx = {ghost_aquaX, ghost_greenX, ghost_redX};
  assign gy = {ghost_aquaY, ghost_greenY, ghost_redY};
  assign fx = {FRUIT_X2, FRUIT_X1, FRUIT_X0};
  assign fy = {FRUIT_Y2, FRUIT_Y1, FRUIT_Y0};

  for (genvar i = 0; i < 3; i++) begin : g_overlap
    sprite_overlap u_ghost (
      .ax  (pacmanX),
      .ay  (pacmanY),
      .bx  (gx[i]),
      .by  (gy[i]),
      .hit (ghost_hit[i])
    );
    sprite_overlap u_fruit (
      .ax  (pacmanX),
      .ay  (pacmanY),
      .bx  (fx[i]),
      .by  (fy[i]),
      .hit (fruit_hit[i])
    );
  end

  assign tick      = frame_clk & ~frame_clk_q;
  assign eaten     = fruit_hit & on_q;
  assign on_after  = on_q & ~eaten;
  assign score_sum = 10'(score_q) + 10'(eaten[0]) + 10'(eaten[1]) + 10'(eaten[2]);

  always_comb begin
    state_d     = state_q;
    on_d        = on_q;
    score_d     = score_q;
    lives_d     = lives_q;
    mouth_cnt_d = mouth_cnt_q;
    death_cnt_d = death_cnt_q;
    close_d     = close_q;
    respawn_d   = 1'b0;

    case (state_q)
      PLAY: begin
        if (tick) begin
          if (|ghost_hit) begin
            // Collision wins: fruit and mouth are left untouched this frame.
            lives_d     = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
            death_cnt_d = 8'd0;
            close_d     = 1'b0;
            state_d     = DYING;
          end else begin
            on_d    = (on_after == 3'b000) ? 3'b111 : on_after;
            score_d = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];
            if (mouth_cnt_q >= MouthLast) begin
              mouth_cnt_d = 8'd0;
              close_d     = ~close_q;
            end else begin
              mouth_cnt_d = mouth_cnt_q + 8'd1;
            end
          end
        end
      end
      DYING: begin
        close_d = 1'b0;
        if (tick) begin
          if (death_cnt_q >= DeathLast) begin
            if (lives_q == 3'd0) begin
              state_d = GAME_OVER;
            end else begin
              respawn_d = 1'b1;
              state_d   = PLAY;
            end
          end else begin
            death_cnt_d = death_cnt_q + 8'd1;
          end
        end
      end
      GAME_OVER: begin
        close_d = 1'b0;
        if (restart) begin
          lives_d     = LivesInit;
          score_d     = 8'd0;
          on_d        = 3'b111;
          mouth_cnt_d = 8'd0;
          respawn_d   = 1'b1;
          state_d     = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= PLAY;
      frame_clk_q <= 1'b0;
      on_q        <= 3'b111;
      score_q     <= 8'd0;
      lives_q     <= LivesInit;
      mouth_cnt_q <= 8'd0;
      death_cnt_q <= 8'd0;
      close_q     <= 1'b0;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk;
      on_q        <= on_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      mouth_cnt_q <= mouth_cnt_d;
      death_cnt_q <= death_cnt_d;
      close_q     <= close_d;
      respawn_q   <= respawn_d;
    end
  end

  assign fruit_location = {FRUIT_X0, FRUIT_Y0, FRUIT_X1, FRUIT_Y1, FRUIT_X2, FRUIT_Y2};
  assign first_on       = on_q[0];
  assign second_on      = on_q[1];
  assign third_on       = on_q[2];
  assign death          = (state_q == GAME_OVER);
  assign closePacman    = close_q;
  assign pacman_respawn = respawn_q;
  assign lives          = lives_q;
  assign score          = score_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed frame ticks push expected outputs,
// a monitor pops and compares them on the due cycle.
module tb_game_state_ctrl;

  localparam int unsigned MF = 8;
  localparam int unsigned DF = 4;
  localparam int unsigned NL = 3;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_clk = 1'b0;
  logic            restart = 1'b0;
  logic [9:0]      pacmanX, pacmanY;
  logic [9:0]      ghost_redX, ghost_redY, ghost_greenX, ghost_greenY, ghost_aquaX, ghost_aquaY;
  logic [5:0][9:0] fruit_location;
  logic            first_on, second_on, third_on, death, closePacman, pacman_respawn;
  logic [2:0]      lives;
  logic [7:0]      score;

  always #5 Clk = ~Clk;

  game_state_ctrl #(
    .LIVES        (NL),
    .MOUTH_FRAMES (MF),
    .DEATH_FRAMES (DF),
    .FRUIT_X0     (10'd104),
    .FRUIT_Y0     (10'd96),
    .FRUIT_X1     (10'd300),
    .FRUIT_Y1     (10'd300),
    .FRUIT_X2     (10'd400),
    .FRUIT_Y2     (10'd50)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .restart        (restart),
    .pacmanX        (pacmanX),
    .pacmanY        (pacmanY),
    .ghost_redX     (ghost_redX),
    .ghost_redY     (ghost_redY),
    .ghost_greenX   (ghost_greenX),
    .ghost_greenY   (ghost_greenY),
    .ghost_aquaX    (ghost_aquaX),
    .ghost_aquaY    (ghost_aquaY),
    .fruit_location (fruit_location),
    .first_on       (first_on),
    .second_on      (second_on),
    .third_on       (third_on),
    .death          (death),
    .closePacman    (closePacman),
    .pacman_respawn (pacman_respawn),
    .lives          (lives),
    .score          (score)
  );

  typedef struct {
    int         due;
    string      name;
    logic [2:0] lives;
    logic [7:0] score;
    logic [2:0] on;
    logic       close;
    logic       death;
    logic       resp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic push(input int due, input string nm, input logic [2:0] l, input logic [7:0] s,
                      input logic [2:0] o, input logic c, input logic d, input logic r);
    exp_t e;
    e.due = due; e.name = nm; e.lives = l; e.score = s; e.on = o;
    e.close = c; e.death = d; e.resp = r;
    sb.push_back(e);
  endtask

  // One frame tick; outputs are expected one Clk later.
  task automatic tick_chk(input string nm, input logic [2:0] l, input logic [7:0] s,
                          input logic [2:0] o, input logic c, input logic d, input logic r);
    @(negedge Clk);
    frame_clk = 1'b1;
    push(cyc + 1, nm, l, s, o, c, d, r);
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic now_chk(input string nm, input logic [2:0] l, input logic [7:0] s,
                         input logic [2:0] o, input logic c, input logic d, input logic r);
    @(negedge Clk);
    push(cyc, nm, l, s, o, c, d, r);
  endtask

  task automatic ghosts_home();
    ghost_redX = 10'd10;   ghost_redY = 10'd10;
    ghost_greenX = 10'd10; ghost_greenY = 10'd200;
    ghost_aquaX = 10'd600; ghost_aquaY = 10'd10;
  endtask

  // Monitor: compare every entry whose due cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (lives !== e.lives || score !== e.score || {third_on, second_on, first_on} !== e.on ||
            closePacman !== e.close || death !== e.death || pacman_respawn !== e.resp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got lives=%0d score=%0d on=%b close=%b death=%b resp=%b, want lives=%0d score=%0d on=%b close=%b death=%b resp=%b",
                   e.name, cyc, lives, score, {third_on, second_on, first_on}, closePacman,
                   death, pacman_respawn, e.lives, e.score, e.on, e.close, e.death, e.resp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [59:0] floc_exp;
    pacmanX = 10'd500; pacmanY = 10'd400;
    ghosts_home();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    now_chk("reset", 3'd3, 8'd0, 3'b111, 1'b0, 1'b0, 1'b0);

    floc_exp = {10'd104, 10'd96, 10'd300, 10'd300, 10'd400, 10'd50};
    n_checks++;
    if (fruit_location !== floc_exp) begin
      n_fail++;
      $display("FAIL fruit_location: got %h, want %h", fruit_location, floc_exp);
    end

    // Mouth animation: toggles after tick 8 and again after tick 16.
    for (int i = 1; i <= 16; i++) tick_chk("mouth", 3'd3, 8'd0, 3'b111, (i >= 8 && i < 16), 1'b0, 1'b0);

    pacmanX = 10'd100; pacmanY = 10'd100;
    tick_chk("eat_f0", 3'd3, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    tick_chk("eat_f0_again", 3'd3, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);

    @(negedge Clk);
    restart = 1'b1;
    push(cyc + 1, "restart_in_play", 3'd3, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    restart = 1'b0;

    pacmanX = 10'd200; pacmanY = 10'd200;
    ghost_redX = 10'd208; ghost_redY = 10'd200;
    tick_chk("ghost_miss", 3'd3, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    ghost_redX = 10'd207; ghost_redY = 10'd193;
    tick_chk("ghost_hit", 3'd2, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick_chk("dying_ignore", 3'd2, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    ghosts_home();
    tick_chk("respawn", 3'd2, 8'd1, 3'b110, 1'b0, 1'b0, 1'b1);
    now_chk("respawn_end", 3'd2, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);

    // Ghost and fruit1 together: collision has priority.
    pacmanX = 10'd300; pacmanY = 10'd300;
    ghost_greenX = 10'd305; ghost_greenY = 10'd302;
    tick_chk("ghost_prio", 3'd1, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    ghosts_home();
    for (int i = 0; i < 3; i++) tick_chk("dying2", 3'd1, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);
    tick_chk("respawn2", 3'd1, 8'd1, 3'b110, 1'b0, 1'b0, 1'b1);
    now_chk("respawn2_end", 3'd1, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);

    tick_chk("eat_f1", 3'd1, 8'd2, 3'b100, 1'b0, 1'b0, 1'b0);

    // Last fruit reloads all three; frame_clk held high must count once.
    pacmanX = 10'd401; pacmanY = 10'd51;
    @(negedge Clk);
    frame_clk = 1'b1;
    push(cyc + 1, "eat_last", 3'd1, 8'd3, 3'b111, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge Clk);
    push(cyc, "hold_high", 3'd1, 8'd3, 3'b111, 1'b0, 1'b0, 1'b0);
    frame_clk = 1'b0;
    pacmanX = 10'd500; pacmanY = 10'd400;

    ghost_redX = 10'd503; ghost_redY = 10'd405;
    tick_chk("last_life", 3'd0, 8'd3, 3'b111, 1'b0, 1'b0, 1'b0);
    ghosts_home();
    for (int i = 0; i < 3; i++) tick_chk("dying3", 3'd0, 8'd3, 3'b111, 1'b0, 1'b0, 1'b0);
    tick_chk("game_over", 3'd0, 8'd3, 3'b111, 1'b0, 1'b1, 1'b0);
    now_chk("no_respawn", 3'd0, 8'd3, 3'b111, 1'b0, 1'b1, 1'b0);

    pacmanX = 10'd104; pacmanY = 10'd96;
    ghost_redX = 10'd104; ghost_redY = 10'd96;
    tick_chk("go_ignore", 3'd0, 8'd3, 3'b111, 1'b0, 1'b1, 1'b0);
    ghosts_home();
    pacmanX = 10'd500; pacmanY = 10'd400;

    @(negedge Clk);
    restart = 1'b1;
    push(cyc + 1, "restart", 3'd3, 8'd0, 3'b111, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    restart = 1'b0;
    now_chk("restart_end", 3'd3, 8'd0, 3'b111, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of DYING.
    ghost_redX = 10'd503; ghost_redY = 10'd405;
    tick_chk("hit_again", 3'd2, 8'd0, 3'b111, 1'b0, 1'b0, 1'b0);
    ghosts_home();
    tick_chk("dying4", 3'd2, 8'd0, 3'b111, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b0;
    push(cyc, "async_reset", 3'd3, 8'd0, 3'b111, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    pacmanX = 10'd104; pacmanY = 10'd96;
    tick_chk("post_reset_tick", 3'd3, 8'd1, 3'b110, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge Clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Per-frame game-rule engine that sits directly upstream of color_mapper. Once per video frame it samples sprite positions, detects Pac-Man/ghost and Pac-Man/fruit overlaps, and manages lives, score and mouth animation. It drives color_mapper's death, closePacman, first_on/second_on/third_on and fruit_location inputs.

Parameters:
LIVES, 3, lives at reset/restart (1..7)
MOUTH_FRAMES, 8, frames per closePacman toggle (1..255)
DEATH_FRAMES, 60, frames spent in DYING before respawn or game over (1..255)
FRUIT_X0/Y0, FRUIT_X1/Y1, FRUIT_X2/Y2, 10-bit constants, top-left positions of the three fruits

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  vsync-derived level from the VGA controller (Clk domain); a rising edge marks one frame tick
restart  in  1  start a new game; honoured only in GAME_OVER
pacmanX, pacmanY  in  10 each  Pac-Man top-left position
ghost_redX/Y, ghost_greenX/Y, ghost_aquaX/Y  in  10 each  ghost top-left positions
fruit_location  out  10 x 6  {X0,Y0,X1,Y1,X2,Y2}, driven from parameters
first_on, second_on, third_on  out  1 each  fruit still present
death  out  1  game over (shows GAME OVER screen)
closePacman  out  1  mouth-closed animation phase
pacman_respawn  out  1  single-Clk pulse telling the Pac-Man motion block to return to spawn
lives  out  3  remaining lives
score  out  8  fruits eaten, saturating at 255

Behaviour:
- Reset values (Reset_n=0, async): state=PLAY; first/second/third_on=1; death=0; closePacman=0; pacman_respawn=0; lives=LIVES; score=0; mouth and death counters=0.
- tick = frame_clk & ~frame_clk_q, where frame_clk_q is a registered copy (reset value 0). All rule evaluation happens only in cycles where tick=1. Outputs update 1 Clk after the tick cycle.
- Overlap test, per sprite pair: dx = {1'b0,A_X} - {1'b0,B_X} and dy formed the same way, both signed 11-bit. Overlap = (-8 < dx < 8) && (-8 < dy < 8). Sprites are 8x8 and no wrap-around occurs.
- State PLAY, on tick:
  - Any ghost overlaps Pac-Man: lives decrements; death_cnt=0; go to DYING. On the same tick, no fruit is eaten and the mouth counter freezes (collision has priority).
  - Otherwise: each present fruit that overlaps Pac-Man clears its _on flag, and score adds 1 per fruit cleared (0..3 per tick, saturating).
  - If all three flags would be 0 after the update, all three reload to 1 on that same tick.
  - Mouth counter increments. When it reaches MOUTH_FRAMES-1 it wraps to 0 and closePacman toggles.
- State DYING:
  - closePacman held at 0; death_cnt increments on each tick.
  - When death_cnt reaches DEATH_FRAMES-1 on a tick: if lives==0, go to GAME_OVER; else pulse pacman_respawn for exactly 1 Clk and go to PLAY.
  - Ghost overlap is ignored while in DYING.
- State GAME_OVER:
  - death=1, closePacman=0; all other tick events ignored.
  - restart=1 (sampled every Clk, not only on tick): reload lives, score and fruit flags to reset values, pulse pacman_respawn, clear death, go to PLAY next Clk.
- restart is ignored in PLAY and DYING.
- lives never underflows: a collision with lives==1 yields lives=0, then DYING, then GAME_OVER.
- Reset_n asserted mid-frame or mid-DYING: immediate return to reset values. The first tick after release is evaluated normally.
- fruit_location is purely combinational from the parameters.

Decomposition:
- Package pacman_pkg: state enum {PLAY, DYING, GAME_OVER}; SPRITE_SIZE=8; default fruit coordinates; color_mapper should import the same coordinates.
- Sub-module sprite_overlap (combinational; inputs ax, ay, bx, by; output hit), instantiated 6 times: 3 ghosts and 3 fruits.

Test Plan:
- Reset, then 16 ticks with no overlaps, MOUTH_FRAMES=8 -> closePacman rises after tick 8 and falls after tick 16; score=0; lives=3; all fruit flags 1.
- Pac-Man at (100,100), fruit0 at (104,96) -> after the next tick first_on=0, score=1. Same position on the following tick -> score stays 1.
- Pac-Man (200,200), red ghost (207,193) -> overlap, lives=2, DYING. Ghost at (208,200) -> no overlap, no change.
- LIVES=1, collision, then DEATH_FRAMES ticks -> death=1 and no pacman_respawn pulse. Then restart=1 for 1 Clk -> death=0, lives=1, pacman_respawn high for 1 Clk.
- Ghost and fruit1 both overlapping Pac-Man on the same tick -> lives decrements, second_on stays 1, score unchanged.
- Eat the last remaining fruit -> all three _on flags read 1 after that tick and score increments; hold frame_clk high for 100 Clk -> only one tick is counted.
